// File: rtl/seg7_pkg.sv
// Shared constants for active-low 7-segment displays: glyphs, anode masks,
// digit slot indices and the blink phase type.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic [1:0] D_ONES  = 2'd0;
    localparam logic [1:0] D_TENS  = 2'd1;
    localparam logic [1:0] D_HUND  = 2'd2;
    localparam logic [1:0] D_SPARE = 2'd3;

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment glyph decoder.
// Non-decimal nibbles show a dash so corrupted scores are visible.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        case (nibble)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Multiplexed 4-digit common-anode scanner for a 3-digit packed BCD score,
// with per-frame snapshot, leading-zero blanking and whole-display blink.
module bcd_seg_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [1:0]    idx;
    logic [1:0]    next_idx;
    logic [11:0]   snap;
    logic [11:0]   frame;
    logic [BW-1:0] blink_cnt;
    logic          blink_wrap;
    blink_phase_t  phase;
    blink_phase_t  next_phase;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    logic          digit_blank;
    logic          dark;

    assign tick       = (pre_cnt == PRE_LAST);
    assign next_idx   = idx + 2'd1;
    assign blink_wrap = (blink_cnt == BLINK_LAST);
    assign next_phase = blink_wrap ? ((phase == PHASE_ON) ? PHASE_OFF : PHASE_ON) : phase;
    assign dp         = 1'b1;

    // The ones slot opens a new frame, so it decodes the score being captured now.
    assign frame = (next_idx == D_ONES) ? bcd : snap;

    always_comb begin
        nibble      = 4'h0;
        digit_blank = 1'b0;
        case (next_idx)
            D_ONES: nibble = frame[3:0];
            D_TENS: begin
                nibble      = frame[7:4];
                digit_blank = blank_lz && (frame[11:8] == 4'h0) && (frame[7:4] == 4'h0);
            end
            D_HUND: begin
                nibble      = frame[11:8];
                digit_blank = blank_lz && (frame[11:8] == 4'h0);
            end
            default: digit_blank = 1'b1;
        endcase
        dark = digit_blank || (blink_en && (next_phase == PHASE_OFF));
    end

    seg7_decode u_decode (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            idx     <= D_ONES;
            snap    <= 12'h000;
        end else if (tick) begin
            pre_cnt <= '0;
            idx     <= next_idx;
            if (next_idx == D_ONES) begin
                snap <= bcd;
            end
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Blink timing free-runs regardless of blink_en so enabling it never restarts the cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= PHASE_ON;
        end else if (tick) begin
            if (blink_wrap) begin
                blink_cnt <= '0;
                phase     <= next_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (tick) begin
            if (dark) begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
            end else begin
                an  <= ~(4'b0001 << next_idx);
                seg <= glyph;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner: table vectors, hand-written
// frame/blink/reset sequences and randomized inputs against a slot-level model.
module tb_bcd_seg_scanner;

    localparam int RD = 4;
    localparam int BT = 3;

    localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
    localparam logic [6:0] G5 = 7'h12, G6 = 7'h02, G7 = 7'h78, G8 = 7'h00, G9 = 7'h10;
    localparam logic [6:0] GDASH = 7'h3F, GBLANK = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd = 12'h123;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int comps = 0;
    int fails = 0;

    bcd_seg_scanner #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd      (bcd),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] refGlyph(input int d);
        case (d)
            0: return G0;  1: return G1;  2: return G2;  3: return G3;
            4: return G4;  5: return G5;  6: return G6;  7: return G7;
            8: return G8;  9: return G9;
            default: return GDASH;
        endcase
    endfunction

    function automatic logic [3:0] anFor(input int slot, input logic [6:0] s);
        logic [3:0] a;
        a = 4'b1111;
        if (s != GBLANK) a[slot] = 1'b0;
        return a;
    endfunction

    // Slot-level model: every RD edges a new slot n starts; slot n%4 shows digit n%4
    // of the frame's score, and the blink phase is OFF whenever floor(n/BT) is odd.
    int          edges;
    logic [11:0] m_snap;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges   = 0;
            m_snap  = 12'h000;
            exp_an  = 4'b1111;
            exp_seg = GBLANK;
        end else begin
            int n, slot, digit;
            bit blanked, darkp;
            edges++;
            if (edges % RD == 0) begin
                n    = edges / RD;
                slot = n % 4;
                if (slot == 0) m_snap = bcd;
                digit   = int'((m_snap >> (4 * slot)) & 12'hF);
                blanked = (slot == 3) ||
                          (blank_lz && slot == 2 && m_snap[11:8] == 0) ||
                          (blank_lz && slot == 1 && m_snap[11:8] == 0 && m_snap[7:4] == 0);
                darkp   = blink_en && ((n / BT) % 2 == 1);
                if (blanked || darkp) begin
                    exp_an  = 4'b1111;
                    exp_seg = GBLANK;
                end else begin
                    exp_an  = 4'b1111;
                    exp_an[slot] = 1'b0;
                    exp_seg = refGlyph(digit);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] ea, input logic [6:0] es);
        comps++;
        if (an !== ea || seg !== es || dp !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                     name, an, seg, dp, ea, es);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] b, input logic lz, input logic be);
        bcd      = b;
        blank_lz = lz;
        blink_en = be;
    endtask

    function automatic bit slotHit(input int s);
        return edges > 0 && edges % RD == 0 && (edges / RD) % 4 == s;
    endfunction

    task automatic waitSlot(input int s);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!slotHit(s) && guard < 200);
        if (!slotHit(s)) begin
            comps++;
            fails++;
            $display("[TB] FAIL slot_timeout: slot %0d not reached, got edges=%0d, expected within 200 cycles", s, edges);
        end
    endtask

    typedef struct {
        logic [11:0] b;
        logic        lz;
        logic [6:0]  s [3];
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{b: 12'h123, lz: 1'b0, s: '{G3, G2, G1}};
        vecs[1] = '{b: 12'h007, lz: 1'b1, s: '{G7, GBLANK, GBLANK}};
        vecs[2] = '{b: 12'h000, lz: 1'b1, s: '{G0, GBLANK, GBLANK}};
        vecs[3] = '{b: 12'h105, lz: 1'b1, s: '{G5, G0, G1}};
        vecs[4] = '{b: 12'h0A0, lz: 1'b1, s: '{G0, GDASH, GBLANK}};
        vecs[5] = '{b: 12'h0A0, lz: 1'b0, s: '{G0, GDASH, G0}};
        vecs[6] = '{b: 12'h050, lz: 1'b1, s: '{G0, G5, GBLANK}};
        vecs[7] = '{b: 12'hF00, lz: 1'b1, s: '{G0, G0, GDASH}};

        // Reset state and the first frame, which still shows the zero snapshot.
        applyStimulus(12'h123, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 4'b1111, GBLANK);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("pre_first_tick", 4'b1111, GBLANK);
        waitSlot(1); checkOutput("frame0_tens", 4'b1101, G0);
        waitSlot(2); checkOutput("frame0_hund", 4'b1011, G0);
        waitSlot(3); checkOutput("frame0_spare", 4'b1111, GBLANK);
        waitSlot(0); checkOutput("frame1_ones", 4'b1110, G3);
        waitSlot(1); checkOutput("frame1_tens", 4'b1101, G2);
        waitSlot(2); checkOutput("frame1_hund", 4'b1011, G1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].b, vecs[i].lz, 1'b0);
            waitSlot(0); checkOutput($sformatf("vec%0d_ones", i), anFor(0, vecs[i].s[0]), vecs[i].s[0]);
            waitSlot(1); checkOutput($sformatf("vec%0d_tens", i), anFor(1, vecs[i].s[1]), vecs[i].s[1]);
            waitSlot(2); checkOutput($sformatf("vec%0d_hund", i), anFor(2, vecs[i].s[2]), vecs[i].s[2]);
            waitSlot(3); checkOutput($sformatf("vec%0d_spare", i), 4'b1111, GBLANK);
        end

        // Mid-frame change must not tear the current frame.
        applyStimulus(12'h111, 1'b0, 1'b0);
        waitSlot(0);
        waitSlot(1); checkOutput("tear_tens_old", 4'b1101, G1);
        applyStimulus(12'h999, 1'b0, 1'b0);
        waitSlot(2); checkOutput("tear_hund_old", 4'b1011, G1);
        waitSlot(0); checkOutput("tear_ones_new", 4'b1110, G9);
        waitSlot(1); checkOutput("tear_tens_new", 4'b1101, G9);
        waitSlot(2); checkOutput("tear_hund_new", 4'b1011, G9);

        // Blink cadence from reset: slots 1,2 on, 3..5 off, 6..8 on, ...
        rst = 1'b1;
        applyStimulus(12'h000, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 24; k++) begin
            int n, slot;
            int guard;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!(edges > 0 && edges % RD == 0) && guard < 20);
            n    = edges / RD;
            slot = n % 4;
            if (((n / BT) % 2 == 1) || slot == 3)
                checkOutput($sformatf("blink_slot%0d", n), 4'b1111, GBLANK);
            else
                checkOutput($sformatf("blink_slot%0d", n), anFor(slot, G0), G0);
        end

        // Asynchronous reset in the middle of a lit slot.
        applyStimulus(12'h000, 1'b0, 1'b0);
        waitSlot(1);
        waitSlot(2);
        @(negedge clk);
        checkOutput("pre_async_rst_lit", 4'b1011, G0);
        #2 rst = 1'b1;
        #1 checkOutput("async_rst_dark", 4'b1111, GBLANK);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_restart_dark", 4'b1111, GBLANK);
        @(negedge clk);
        checkOutput("rst_restart_tens", 4'b1101, G0);

        // Randomized inputs against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checkOutput("random", exp_an, exp_seg);
            if ($urandom_range(0, 9) == 0) begin
                logic [11:0] nb;
                nb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                if ($urandom_range(0, 9) == 0) nb[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
                if ($urandom_range(0, 3) == 0) nb[11:8] = 4'h0;
                if ($urandom_range(0, 5) == 0) nb[7:4] = 4'h0;
                bcd = nb;
            end
            if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

endmodule
